// File: rtl/colour_rom_reader_if.sv
// Stream and ROM-bus bundle for colour_rom_reader: upstream index handshake,
// downstream colour handshake, and the registered-read ROM port.
interface colour_rom_reader_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 12
);
    // valid/ready: a transfer happens on a rising edge where both are high;
    // the source keeps payload stable while valid is high and not yet taken.
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_idx;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_dout;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_colour;

    modport master (
        input  in_valid, in_idx, rom_dout, out_ready,
        output in_ready, rom_en, rom_addr, out_valid, out_colour
    );

    modport slave (
        output in_valid, in_idx, rom_dout, out_ready,
        input  in_ready, rom_en, rom_addr, out_valid, out_colour
    );
endinterface

// File: rtl/colour_rom_reader.sv
// Colour ROM initiator: indices in, 12-bit colours out through a 3-entry buffer.
// Optional full-ROM sweep enabled by defining COLOUR_ROM_READER_SWEEP_EN.
module colour_rom_reader #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 12,
    parameter int DEPTH  = 2048
) (
    input  logic clk,
    input  logic rst_n,
`ifdef COLOUR_ROM_READER_SWEEP_EN
    input  logic sweep_start,
    output logic sweep_busy,
    output logic out_last,
`endif
    colour_rom_reader_if.master bus
);

    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    logic [1:0]        occ;
    logic [1:0]        rd_ptr;
    logic [1:0]        wr_ptr;
    logic              pend;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] buf_mem [3];

    logic              credit;
    logic              busy;
    logic              accept;
    logic              sweep_issue;
    logic              issue;
    logic [ADDR_W-1:0] idx_clamped;
    logic [ADDR_W-1:0] issue_addr;
    logic              push;
    logic              pop;

    // Credits count both buffered words and the read still in the ROM pipe,
    // so the buffer can never be overrun and out_ready never reaches in_ready.
    assign credit      = ({1'b0, occ} + {2'b00, pend}) < 3'd3;
    assign bus.in_ready = rst_n && !busy && credit;
    assign accept      = bus.in_valid && bus.in_ready;
    assign idx_clamped = ({1'b0, bus.in_idx} >= DEPTH_X) ? LAST_ADDR : bus.in_idx;
    assign issue       = accept || sweep_issue;

    assign bus.rom_en     = issue;
    assign bus.rom_addr   = issue ? issue_addr : last_addr;
    assign bus.out_valid  = (occ != 2'd0);
    assign bus.out_colour = buf_mem[rd_ptr];

    assign push = pend;
    assign pop  = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ       <= 2'd0;
            rd_ptr    <= 2'd0;
            wr_ptr    <= 2'd0;
            pend      <= 1'b0;
            last_addr <= '0;
            for (int i = 0; i < 3; i++) buf_mem[i] <= '0;
        end else begin
            pend <= issue;
            if (issue) last_addr <= issue_addr;
            if (push) begin
                buf_mem[wr_ptr] <= bus.rom_dout;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            unique case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

`ifdef COLOUR_ROM_READER_SWEEP_EN
    typedef enum logic {SW_IDLE, SW_RUN} sweep_state_t;

    sweep_state_t      state;
    sweep_state_t      state_next;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_next;
    logic              pend_last;
    logic              buf_last [3];

    assign busy        = (state == SW_RUN);
    assign sweep_busy  = busy;
    assign sweep_issue = busy && credit;
    assign issue_addr  = sweep_issue ? cnt : idx_clamped;
    assign out_last    = bus.out_valid && buf_last[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SW_IDLE;
            cnt       <= '0;
            pend_last <= 1'b0;
            for (int i = 0; i < 3; i++) buf_last[i] <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            pend_last <= sweep_issue && (cnt == LAST_ADDR);
            if (push) buf_last[wr_ptr] <= pend_last;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            SW_IDLE: begin
                if (sweep_start) begin
                    state_next = SW_RUN;
                    cnt_next   = '0;
                end
            end
            SW_RUN: begin
                // The edge that issues the final address also ends the sweep.
                if (sweep_issue) begin
                    if (cnt == LAST_ADDR) state_next = SW_IDLE;
                    else                  cnt_next   = cnt + 1'b1;
                end
            end
            default: state_next = SW_IDLE;
        endcase
    end
`else
    assign busy        = 1'b0;
    assign sweep_issue = 1'b0;
    assign issue_addr  = idx_clamped;
`endif

endmodule

// File: doc/colour_rom_reader.md
Name: colour_rom_reader

Overview:
- Initiator side of the colour ROM read interface (ROM: clk, en, addr, dout; registered read, 1-cycle latency).
- Accepts colour indices from upstream on a valid/ready handshake and issues ROM reads.
- Absorbs the ROM latency in a 3-entry output buffer and delivers 12-bit colours downstream on a valid/ready handshake.
- Sits between the lava-lamp index generator and the pixel output stage; sustains 1 colour/cycle.

Parameters:
- ADDR_W, 11, ROM address width.
- DATA_W, 12, colour word width (RGB444).
- DEPTH, 2048, number of valid ROM entries (DEPTH <= 2**ADDR_W).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream index valid.
- in_ready  output  1  block can accept an index.
- in_idx  input  ADDR_W  colour index.
- rom_en  output  1  ROM read enable.
- rom_addr  output  ADDR_W  ROM address.
- rom_dout  input  DATA_W  ROM data, valid the cycle after an rom_en edge.
- out_valid  output  1  colour available.
- out_ready  input  1  downstream accepts colour.
- out_colour  output  DATA_W  colour word.
- sweep_start  input  1  (SWEEP_EN only) start full-ROM sweep.
- sweep_busy  output  1  (SWEEP_EN only) sweep in progress.
- out_last  output  1  (SWEEP_EN only) marks final sweep colour.

Behaviour:
- Reset (rst_n low, async): buffer emptied, pend=0, sweep idle.
  - Outputs while rst_n low: out_valid=0, in_ready=0, rom_en=0, rom_addr=0, out_colour=0, sweep_busy=0, out_last=0.
- State:
  - occ: buffer occupancy, 0..3.
  - pend: 1 when a ROM read was issued last edge.
- in_ready = rst_n && !sweep_busy && (occ + pend < 3).
  - Computed from registers only; no combinational path from out_ready.
- Accept: in_valid && in_ready drives rom_en=1 and rom_addr=in_idx in the same cycle (combinational).
  - Index >= DEPTH is clamped to DEPTH-1.
  - When not accepting: rom_en=0 and rom_addr holds its last issued value.
- Read sequencing:
  - pend is set at the accepting edge.
  - In the following cycle rom_dout is written into the buffer tail at the next edge, and pend clears unless a new read was accepted.
- Latency: index accepted at edge k gives out_valid=1 in the cycle after edge k+1, provided the buffer was empty.
- Output: out_valid = (occ != 0); out_colour = buffer head. Head pops on out_valid && out_ready.
- Simultaneous push and pop in one edge leaves occ unchanged; order is preserved (strict FIFO).
- Full: occ + pend = 3 forces in_ready=0. The credit rule guarantees the buffer never overflows.
- Throughput: with out_ready held high, one colour per cycle indefinitely.
- With out_ready low: at most 3 colours are buffered, then in_ready drops.
- Reset mid-operation discards in-flight reads and buffered colours. No output is produced for them after reset release.

Optional Feature:
- Macro: COLOUR_ROM_READER_SWEEP_EN.
- Defined: adds sweep_start, sweep_busy and out_last.
  - Starting a sweep: a sweep_start pulse while !sweep_busy sets sweep_busy at the next edge. An upstream accept in that same cycle proceeds normally. sweep_start while busy is ignored.
  - During the sweep: in_ready=0, and the internal counter issues addresses 0..DEPTH-1 under the same credit rule.
  - Ending the sweep: sweep_busy clears at the edge that issues DEPTH-1.
  - out_last=1 together with the colour read from DEPTH-1; otherwise 0.
- Undefined: these ports and the counter are absent; the block behaves exactly as described above.

Test Plan:
- Reset then idle, no stimulus:
  - out_valid=0 and rom_en=0 throughout.
  - in_ready=1 from the first edge after rst_n rises.
- Single read, ROM model loaded from colour.data:
  - in_idx=0x005 accepted at edge k.
  - rom_en=1 and rom_addr=0x005 in that cycle.
  - out_valid=1 with out_colour=word[5] after edge k+1.
- Streaming idx 0..2047, out_ready=1:
  - 2048 colours delivered in order, matching colour.data.
  - No gaps after the first output.
  - Total 2049 cycles from the first accept.
- Backpressure: out_ready=0, in_valid=1 with idx 10,11,12,13:
  - Exactly 3 accepted, then in_ready=0.
  - On out_ready=1, outputs are word[10], word[11], word[12], then word[13].
- rst_n pulsed low while occ=2 and pend=1:
  - All outputs 0 immediately.
  - After release, no stale colour appears and the next read returns the correct word.
- SWEEP_EN defined: sweep_start pulse with out_ready=1:
  - 2048 colours delivered, equal to colour.data.
  - out_last=1 only on the final colour.
  - in_ready=0 while sweep_busy=1.
  - Second sweep_start mid-sweep has no effect.
